// File: rtl/tpiu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tpiu_pkg : shared TPIU sync constants and frame-sync state type
// rev 1.0
// ------------------------------------------------------------------
package tpiu_pkg;

  localparam logic [31:0] TPIU_FULL_SYNC = 32'h7FFF_FFFF;
  localparam logic [15:0] TPIU_HALF_SYNC = 16'h7FFF;
  localparam int          FRAME_BYTES    = 16;
  localparam int          POS_W          = $clog2(FRAME_BYTES);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(FRAME_BYTES - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tpiu_state_e;

endpackage
`default_nettype wire

// File: rtl/tpiu_nibble_window.sv
`default_nettype none
// ------------------------------------------------------------------
// tpiu_nibble_window : 8-deep tagged nibble shift register with sync compares
// rev 1.0
// ------------------------------------------------------------------
module tpiu_nibble_window
  import tpiu_pkg::*;
(
  input  logic       trace_clk,
  input  logic       reset,
  input  logic       shift_en,
  input  logic [3:0] nibble_in,
  input  logic [7:0] clear_mask,
  output logic [3:0] tail_nibble,
  output logic       tail_valid,
  output logic       full_match,
  output logic       half_match
);

  // Head nibble lives in win_q[31:28], tail in win_q[3:0].
  logic [31:0] win_q, win_d;
  logic [7:0]  vld_q, vld_d;

  always_comb begin
    win_d = win_q;
    vld_d = vld_q;
    if (!shift_en) begin
      vld_d = '0;
    end else begin
      win_d = {nibble_in, win_q[31:4]};
      vld_d = {1'b1, vld_q[7:1] & ~clear_mask[7:1]};
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      win_q <= '0;
      vld_q <= '0;
    end else begin
      win_q <= win_d;
      vld_q <= vld_d;
    end
  end

  // The exiting nibble is live only if this edge is not squashing it.
  assign tail_nibble = win_q[3:0];
  assign tail_valid  = vld_q[0] & ~clear_mask[0];
  assign full_match  = (win_q == TPIU_FULL_SYNC) && (&vld_q);
  assign half_match  = (win_q[15:0] == TPIU_HALF_SYNC) && (&vld_q[3:0]);

endmodule
`default_nettype wire

// File: rtl/tpiu_frame_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// tpiu_frame_sync : TPIU full-sync lock, padding squash, byte/frame assembly
// rev 1.0
// ------------------------------------------------------------------
module tpiu_frame_sync
  import tpiu_pkg::*;
#(
  parameter int unsigned pCNT_WIDTH     = 16,
  parameter bit          pDROP_HALFSYNC = 1'b1
) (
  input  logic                  trace_clk,
  input  logic                  reset,
  input  logic                  I_enable,
  input  logic [3:0]            I_trace_data,
  input  logic                  I_clear_counts,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_frame_start,
  output logic [3:0]            O_frame_pos,
  output logic                  O_locked,
  output logic [pCNT_WIDTH-1:0] O_sync_count,
  output logic [pCNT_WIDTH-1:0] O_err_count
);

  tpiu_state_e state_q, state_d;

  logic [3:0]       tail_nibble;
  logic             tail_valid, full_match, half_match;
  logic             w_full, w_half, w_take, w_misaligned;
  logic [7:0]       w_clear_mask;
  logic             locked;

  logic             phase_q, phase_d;
  logic [3:0]       low_q, low_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic             s1_vld_q, s1_vld_d;
  logic [7:0]       s1_data_q, s1_data_d;
  logic [POS_W-1:0] s1_pos_q, s1_pos_d;

  logic             out_vld_q, out_vld_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [POS_W-1:0] out_pos_q, out_pos_d;
  logic             out_start_q, out_start_d;

  logic [pCNT_WIDTH-1:0] sync_cnt_q, sync_cnt_d;
  logic [pCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  tpiu_nibble_window u_window (
    .trace_clk   (trace_clk),
    .reset       (reset),
    .shift_en    (I_enable),
    .nibble_in   (I_trace_data),
    .clear_mask  (w_clear_mask),
    .tail_nibble (tail_nibble),
    .tail_valid  (tail_valid),
    .full_match  (full_match),
    .half_match  (half_match)
  );

  // Full sync outranks halfword sync; both squash the exiting tail nibble.
  always_comb begin
    w_full       = I_enable & full_match;
    w_half       = pDROP_HALFSYNC & I_enable & (state_q == LOCKED) & half_match
                   & ~phase_q & ~pos_q[0] & ~w_full;
    w_clear_mask = w_full ? 8'hFF : (w_half ? 8'h0F : 8'h00);
    w_take       = I_enable & (state_q == LOCKED) & tail_valid;
    w_misaligned = (state_q == LOCKED) & (phase_q | (pos_q != '0));
  end

  always_ff @(posedge trace_clk) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!I_enable)   state_d = HUNT;
    else if (w_full) state_d = LOCKED;
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  always_comb begin
    phase_d   = phase_q;
    low_d     = low_q;
    pos_d     = pos_q;
    s1_vld_d  = 1'b0;
    s1_data_d = s1_data_q;
    s1_pos_d  = s1_pos_q;
    if (!I_enable || w_full) begin
      phase_d = 1'b0;
      pos_d   = '0;
    end else if (w_take) begin
      if (!phase_q) begin
        low_d   = tail_nibble;
        phase_d = 1'b1;
      end else begin
        s1_vld_d  = 1'b1;
        s1_data_d = {tail_nibble, low_q};
        s1_pos_d  = pos_q;
        pos_d     = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
        phase_d   = 1'b0;
      end
    end
  end

  // Extra register stage gives the fixed nine-edge latency.
  always_comb begin
    out_vld_d  = I_enable & s1_vld_q;
    out_data_d = out_data_q;
    out_pos_d  = out_pos_q;
    if (out_vld_d) begin
      out_data_d = s1_data_q;
      out_pos_d  = s1_pos_q;
    end
    out_start_d = out_vld_d & (s1_pos_q == '0);
  end

  always_comb begin
    sync_cnt_d = sync_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (I_clear_counts) begin
      sync_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (w_full) begin
      if (sync_cnt_q != '1)                sync_cnt_d = sync_cnt_q + pCNT_WIDTH'(1);
      if (w_misaligned && err_cnt_q != '1) err_cnt_d  = err_cnt_q + pCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      phase_q     <= 1'b0;
      low_q       <= '0;
      pos_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_pos_q    <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_pos_q   <= '0;
      out_start_q <= 1'b0;
      sync_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      low_q       <= low_d;
      pos_q       <= pos_d;
      s1_vld_q    <= s1_vld_d;
      s1_data_q   <= s1_data_d;
      s1_pos_q    <= s1_pos_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_pos_q   <= out_pos_d;
      out_start_q <= out_start_d;
      sync_cnt_q  <= sync_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign O_data        = out_data_q;
  assign O_data_valid  = out_vld_q;
  assign O_frame_start = out_start_q;
  assign O_frame_pos   = out_pos_q;
  assign O_locked      = locked;
  assign O_sync_count  = sync_cnt_q;
  assign O_err_count   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tpiu_frame_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tpiu_frame_sync : directed self-checking bench for tpiu_frame_sync
// rev 1.0
// ------------------------------------------------------------------
module tb_tpiu_frame_sync;

  logic        trace_clk;
  logic        reset;
  logic        I_enable;
  logic [3:0]  I_trace_data;
  logic        I_clear_counts;

  logic [7:0]  o_data;
  logic        o_data_valid, o_frame_start, o_locked;
  logic [3:0]  o_frame_pos;
  logic [15:0] o_sync_count, o_err_count;

  logic [7:0]  nd_data;
  logic        nd_data_valid, nd_frame_start, nd_locked;
  logic [3:0]  nd_frame_pos;
  logic [1:0]  nd_sync_count, nd_err_count;

  tpiu_frame_sync #(.pCNT_WIDTH(16), .pDROP_HALFSYNC(1'b1)) dut (
    .trace_clk      (trace_clk),
    .reset          (reset),
    .I_enable       (I_enable),
    .I_trace_data   (I_trace_data),
    .I_clear_counts (I_clear_counts),
    .O_data         (o_data),
    .O_data_valid   (o_data_valid),
    .O_frame_start  (o_frame_start),
    .O_frame_pos    (o_frame_pos),
    .O_locked       (o_locked),
    .O_sync_count   (o_sync_count),
    .O_err_count    (o_err_count)
  );

  // Second instance: halfword syncs pass through, 2-bit counters to reach saturation.
  tpiu_frame_sync #(.pCNT_WIDTH(2), .pDROP_HALFSYNC(1'b0)) dut_nd (
    .trace_clk      (trace_clk),
    .reset          (reset),
    .I_enable       (I_enable),
    .I_trace_data   (I_trace_data),
    .I_clear_counts (I_clear_counts),
    .O_data         (nd_data),
    .O_data_valid   (nd_data_valid),
    .O_frame_start  (nd_frame_start),
    .O_frame_pos    (nd_frame_pos),
    .O_locked       (nd_locked),
    .O_sync_count   (nd_sync_count),
    .O_err_count    (nd_err_count)
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [3:0] pos;
    logic       st;
  } rec_t;

  rec_t recs[$];
  rec_t recs_nd[$];
  int   cyc = 0;
  int   last_cyc;
  int   base, base_nd;
  int   total = 0;
  int   bad = 0;
  int   ca, cc, c65;

  initial trace_clk = 1'b0;
  always #5 trace_clk = ~trace_clk;

  always @(posedge trace_clk) begin
    cyc = cyc + 1;
    #1;
    if (o_data_valid)  recs.push_back('{cyc, o_data, o_frame_pos, o_frame_start});
    if (nd_data_valid) recs_nd.push_back('{cyc, nd_data, nd_frame_pos, nd_frame_start});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] n, input logic en = 1'b1, input logic clr = 1'b0);
    @(negedge trace_clk);
    I_trace_data   = n;
    I_enable       = en;
    I_clear_counts = clr;
    @(posedge trace_clk);
    #2;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) send(4'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send(b[3:0]);
    send(b[7:4]);
  endtask

  task automatic send_sync();
    repeat (7) send(4'hF);
    send(4'h7);
  endtask

  task automatic do_reset();
    @(negedge trace_clk);
    reset          = 1'b1;
    I_enable       = 1'b1;
    I_trace_data   = 4'h0;
    I_clear_counts = 1'b0;
    @(posedge trace_clk);
    @(posedge trace_clk);
    #2;
    base    = recs.size();
    base_nd = recs_nd.size();
    @(negedge trace_clk);
    reset = 1'b0;
  endtask

  task automatic chk_rec(input bit nd, input int idx, input string tag, input logic [7:0] d,
                         input logic [3:0] p, input logic st, input int ecyc);
    rec_t r;
    int   n;
    int   bi;
    bi = (nd ? base_nd : base) + idx;
    n  = nd ? recs_nd.size() : recs.size();
    chk({tag, "_present"}, 32'(n > bi), 32'd1);
    if (n > bi) begin
      r = nd ? recs_nd[bi] : recs[bi];
      chk({tag, "_data"},  32'(r.d),   32'(d));
      chk({tag, "_pos"},   32'(r.pos), 32'(p));
      chk({tag, "_start"}, 32'(r.st),  32'(st));
      if (ecyc >= 0) chk({tag, "_cyc"}, 32'(r.cyc), 32'(ecyc));
    end
  endtask

  initial begin
    reset          = 1'b1;
    I_enable       = 1'b1;
    I_trace_data   = 4'h0;
    I_clear_counts = 1'b0;
    repeat (3) @(posedge trace_clk);
    #2;
    chk("rst_valid",  32'(o_data_valid),  32'd0);
    chk("rst_data",   32'(o_data),        32'd0);
    chk("rst_pos",    32'(o_frame_pos),   32'd0);
    chk("rst_start",  32'(o_frame_start), 32'd0);
    chk("rst_locked", 32'(o_locked),      32'd0);
    chk("rst_sync",   32'(o_sync_count),  32'd0);
    chk("rst_err",    32'(o_err_count),   32'd0);
    @(negedge trace_clk);
    reset = 1'b0;

    // Sync-free noise: never 0xF, so no sync can form.
    base = recs.size();
    for (int i = 0; i < 200; i++) send(4'($urandom_range(0, 6)));
    chk("hunt_locked", 32'(o_locked), 32'd0);
    chk("hunt_bytes",  32'(recs.size() - base), 32'd0);
    chk("hunt_sync",   32'(o_sync_count), 32'd0);
    chk("hunt_err",    32'(o_err_count),  32'd0);

    // Lock then two bytes with exact latency.
    do_reset();
    send_sync();
    send(4'h3);
    send(4'hA); ca = last_cyc;
    send(4'h5);
    send(4'hC); cc = last_cyc;
    idle(14);
    chk("lock_locked", 32'(o_locked), 32'd1);
    chk("lock_sync",   32'(o_sync_count), 32'd1);
    chk("lock_err",    32'(o_err_count), 32'd0);
    chk_rec(1'b0, 0, "lock_b0", 8'hA3, 4'd0, 1'b1, ca + 9);
    chk_rec(1'b0, 1, "lock_b1", 8'hC5, 4'd1, 1'b0, cc + 9);

    // Misaligned resync after three bytes.
    do_reset();
    send_sync();
    send_byte(8'h21);
    send_byte(8'h43);
    send_byte(8'h65);
    send_sync();
    send_byte(8'h89);
    idle(14);
    chk("mis_err",  32'(o_err_count),  32'd1);
    chk("mis_sync", 32'(o_sync_count), 32'd2);
    chk("mis_err_nd", 32'(nd_err_count), 32'd1);
    chk_rec(1'b0, 2, "mis_b2", 8'h65, 4'd2, 1'b0, -1);
    chk_rec(1'b0, 3, "mis_b3", 8'h89, 4'd0, 1'b1, -1);

    // Halfword sync: dropped in dut, data in dut_nd.
    do_reset();
    send_sync();
    send_byte(8'h21);
    send_byte(8'h43);
    send(4'hF); send(4'hF); send(4'hF); send(4'h7);
    send_byte(8'h65); c65 = last_cyc;
    idle(14);
    chk_rec(1'b0, 1, "hs_b1", 8'h43, 4'd1, 1'b0, -1);
    chk_rec(1'b0, 2, "hs_b2", 8'h65, 4'd2, 1'b0, c65 + 9);
    chk_rec(1'b1, 2, "hsnd_b2", 8'hFF, 4'd2, 1'b0, -1);
    chk_rec(1'b1, 3, "hsnd_b3", 8'h7F, 4'd3, 1'b0, -1);
    chk_rec(1'b1, 4, "hsnd_b4", 8'h65, 4'd4, 1'b0, c65 + 9);

    // Frame position wrap over 17 bytes.
    do_reset();
    send_sync();
    for (int k = 0; k < 17; k++) send_byte(8'(k));
    idle(14);
    chk_rec(1'b0, 0,  "wrap_b0",  8'h00, 4'd0,  1'b1, -1);
    chk_rec(1'b0, 1,  "wrap_b1",  8'h01, 4'd1,  1'b0, -1);
    chk_rec(1'b0, 15, "wrap_b15", 8'h0F, 4'd15, 1'b0, -1);
    chk_rec(1'b0, 16, "wrap_b16", 8'h10, 4'd0,  1'b1, -1);

    // Disable mid-byte, then relock with a simultaneous count clear.
    do_reset();
    send_sync();
    send(4'h3); send(4'hA); send(4'h5);
    send(4'h0, 1'b0, 1'b0);
    send(4'h0, 1'b0, 1'b0);
    idle(20);
    chk("dis_locked", 32'(o_locked), 32'd0);
    chk("dis_bytes",  32'(recs.size() - base), 32'd0);
    chk("dis_sync",   32'(o_sync_count), 32'd1);
    send_sync();
    send(4'h0, 1'b1, 1'b1);
    idle(2);
    chk("clr_locked", 32'(o_locked), 32'd1);
    chk("clr_sync",   32'(o_sync_count), 32'd0);
    chk("clr_err",    32'(o_err_count), 32'd0);

    // Reset mid-byte.
    do_reset();
    send_sync();
    send(4'h3); send(4'hA); send(4'h5);
    do_reset();
    idle(20);
    chk("mrst_locked", 32'(o_locked), 32'd0);
    chk("mrst_bytes",  32'(recs.size() - base), 32'd0);
    chk("mrst_sync",   32'(o_sync_count), 32'd0);
    send_sync();
    idle(1);
    chk("relock_locked", 32'(o_locked), 32'd1);
    chk("relock_sync",   32'(o_sync_count), 32'd1);

    // Back-to-back aligned syncs: 2-bit counter saturates at 3.
    do_reset();
    repeat (4) send_sync();
    idle(1);
    chk("sat_sync",    32'(o_sync_count),  32'd4);
    chk("sat_sync_nd", 32'(nd_sync_count), 32'd3);
    chk("sat_err",     32'(o_err_count),   32'd0);
    chk("sat_locked_nd", 32'(nd_locked),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
